// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: holds the PLL in reset, waits for a debounced lock, then releases per-domain
// resets one by one. Optional macro PLL_SEQ_LOSS_FILTER_EN filters short lock drops in RELEASE/RUN.
module pll_lock_sequencer #(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 1048576,
  parameter int unsigned STAGE_GAP_CYC    = 64,
  parameter int unsigned LOSS_FILTER_CYC  = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              pll_locked_raw,
  output logic              pll_reset,
  output logic [NUM_CH-1:0] ch_reset,
  output logic              ready,
  output logic [7:0]        lock_loss_count,
  output logic [1:0]        seq_state
);

  localparam int RstW  = $clog2(PLL_RST_CYC + 1);
  localparam int TmoW  = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int StabW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int GapW  = $clog2(STAGE_GAP_CYC + 1);

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StRelease  = 2'd2,
    StRun      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [StabW-1:0]  stab_q, stab_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              pll_reset_q, pll_reset_d;
  logic [NUM_CH-1:0] ch_reset_q, ch_reset_d;
  logic              ready_q, ready_d;
  logic [7:0]        loss_q, loss_d;
  logic              sync1_q, lock_s_q;
  logic              loss_event;

`ifdef PLL_SEQ_LOSS_FILTER_EN
  localparam int FltW = $clog2(LOSS_FILTER_CYC + 1);
  logic [FltW-1:0] flt_q, flt_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) flt_q <= '0;
    else     flt_q <= flt_d;
  end

  // Loss only after LOSS_FILTER_CYC consecutive low samples while released.
  always_comb begin
    loss_event = !lock_s_q && (flt_q == FltW'(LOSS_FILTER_CYC - 1));
    flt_d      = '0;
    if ((state_q == StRelease || state_q == StRun) && !lock_s_q && !loss_event) begin
      flt_d = flt_q + FltW'(1);
    end
  end
`else
  logic unused_filter_cfg;
  assign unused_filter_cfg = ^LOSS_FILTER_CYC;
  assign loss_event        = !lock_s_q;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked_raw;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= StPllRst;
      rst_cnt_q   <= '0;
      tmo_q       <= '0;
      stab_q      <= '0;
      gap_q       <= '0;
      pll_reset_q <= 1'b1;
      ch_reset_q  <= '1;
      ready_q     <= 1'b0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_q       <= tmo_d;
      stab_q      <= stab_d;
      gap_q       <= gap_d;
      pll_reset_q <= pll_reset_d;
      ch_reset_q  <= ch_reset_d;
      ready_q     <= ready_d;
      loss_q      <= loss_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    tmo_d       = tmo_q;
    stab_d      = stab_q;
    gap_d       = gap_q;
    pll_reset_d = pll_reset_q;
    ch_reset_d  = ch_reset_q;
    ready_d     = ready_q;
    loss_d      = loss_q;
    unique case (state_q)
      StPllRst: begin
        if (rst_cnt_q == RstW'(PLL_RST_CYC - 1)) begin
          state_d     = StWaitLock;
          rst_cnt_d   = '0;
          pll_reset_d = 1'b0;
          tmo_d       = '0;
          stab_d      = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StWaitLock: begin
        tmo_d  = tmo_q + TmoW'(1);
        stab_d = lock_s_q ? stab_q + StabW'(1) : '0;
        // Stable completion beats timeout when both land on the same cycle.
        if (lock_s_q && stab_q == StabW'(LOCK_STABLE_CYC - 1)) begin
          ch_reset_d = ch_reset_q << 1;
          gap_d      = '0;
          tmo_d      = '0;
          stab_d     = '0;
          if (ch_reset_d == '0) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else if (tmo_q == TmoW'(LOCK_TIMEOUT_CYC - 1)) begin
          state_d     = StPllRst;
          pll_reset_d = 1'b1;
          rst_cnt_d   = '0;
          tmo_d       = '0;
          stab_d      = '0;
        end
      end
      StRelease, StRun: begin
        if (loss_event) begin
          state_d    = StWaitLock;
          ch_reset_d = '1;
          ready_d    = 1'b0;
          tmo_d      = '0;
          stab_d     = '0;
          gap_d      = '0;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (state_q == StRelease) begin
          // Shifting a zero in from bit 0 clears channels in ascending order.
          if (gap_q == GapW'(STAGE_GAP_CYC - 1)) begin
            gap_d      = '0;
            ch_reset_d = ch_reset_q << 1;
            if (ch_reset_d == '0) begin
              state_d = StRun;
              ready_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
      end
      default: state_d = StPllRst;
    endcase
  end

  assign pll_reset       = pll_reset_q;
  assign ch_reset        = ch_reset_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;
  assign seq_state       = state_q;

endmodule
